// File: rtl/ctrl_pipe_unit_if.sv
// ctrl_pipe_unit_if: bundles the decode inputs and the pipelined control
// outputs of ctrl_pipe_unit.
//   slave  : control unit side (takes D-stage fields and zero_e, drives controls)
//   master : datapath side (drives D-stage fields and zero_e, takes controls)
interface ctrl_pipe_unit_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic [6:0]            op_d;
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  zero_e;

  logic [2:0]            imm_src_d;
  logic                  reg_write_e;
  logic                  mem_write_e;
  logic                  alu_src_e;
  logic                  branch_e;
  logic                  jump_e;
  logic                  jalr_e;
  logic [1:0]            result_src_e;
  logic [1:0]            alu_op_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic                  pc_src_e;

  logic                  reg_write_m;
  logic                  mem_write_m;
  logic [1:0]            result_src_m;
  logic [REG_ADDR_W-1:0] rd_m;

  logic                  reg_write_w;
  logic [1:0]            result_src_w;
  logic [REG_ADDR_W-1:0] rd_w;

  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic                  illegal_w;

  modport slave (
    input  op_d, rs1_d, rs2_d, rd_d, zero_e,
    output imm_src_d,
    output reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e,
    output result_src_e, alu_op_e, rd_e, pc_src_e,
    output reg_write_m, mem_write_m, result_src_m, rd_m,
    output reg_write_w, result_src_w, rd_w,
    output stall_f, stall_d, flush_d, flush_e, illegal_w
  );

  modport master (
    output op_d, rs1_d, rs2_d, rd_d, zero_e,
    input  imm_src_d,
    input  reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e,
    input  result_src_e, alu_op_e, rd_e, pc_src_e,
    input  reg_write_m, mem_write_m, result_src_m, rd_m,
    input  reg_write_w, result_src_w, rd_w,
    input  stall_f, stall_d, flush_d, flush_e, illegal_w
  );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: RV32 pipelined control unit. Decodes the D-stage opcode,
// carries the control bundle through D->E->M->W registers and produces the
// load-use stall and branch/jump flush controls.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset, clears every pipeline register
//   bus  : ctrl_pipe_unit_if.slave (D-stage fields in; E/M/W controls,
//          imm_src_d and hazard controls out)
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to pipeline an illegal-opcode
// flag to illegal_w; otherwise illegal_w is tied low.
module ctrl_pipe_unit #(
  parameter int unsigned REG_ADDR_W     = 5,
  parameter bit          ZERO_REG_GUARD = 1'b1
) (
  input logic             clk,
  input logic             rst,
  ctrl_pipe_unit_if.slave bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       aluSrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] resultSrc;
    logic [1:0] aluOp;
  } ctrlBundle_t;

  ctrlBundle_t           decCtrl;
  logic [2:0]            immSrc;
  ctrlBundle_t           ctrlE;
  logic [REG_ADDR_W-1:0] rdE;
  logic                  regWriteM;
  logic                  memWriteM;
  logic [1:0]            resultSrcM;
  logic [REG_ADDR_W-1:0] rdM;
  logic                  regWriteW;
  logic [1:0]            resultSrcW;
  logic [REG_ADDR_W-1:0] rdW;
  logic                  lwStall;
  logic                  pcSrc;
  logic                  flushE;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                  decIllegal;
  logic                  illegalE;
  logic                  illegalM;
  logic                  illegalW;
`endif

  // Opcode decode; unknown opcodes leave every control at zero.
  always_comb begin
    decCtrl = '0;
    immSrc  = 3'b000;
`ifdef CTRL_ILLEGAL_TRAP_EN
    decIllegal = 1'b0;
`endif
    case (bus.op_d)
      OP_LW: begin
        decCtrl.regWrite  = 1'b1;
        decCtrl.aluSrc    = 1'b1;
        decCtrl.resultSrc = 2'b01;
      end
      OP_SW: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.memWrite = 1'b1;
        immSrc           = 3'b001;
      end
      OP_R: begin
        decCtrl.regWrite = 1'b1;
        decCtrl.aluOp    = 2'b10;
      end
      OP_IALU: begin
        decCtrl.regWrite = 1'b1;
        decCtrl.aluSrc   = 1'b1;
        decCtrl.aluOp    = 2'b10;
      end
      OP_BEQ: begin
        decCtrl.branch = 1'b1;
        decCtrl.aluOp  = 2'b01;
        immSrc         = 3'b010;
      end
      OP_JAL: begin
        decCtrl.regWrite  = 1'b1;
        decCtrl.resultSrc = 2'b10;
        decCtrl.jump      = 1'b1;
        immSrc            = 3'b011;
      end
      OP_JALR: begin
        decCtrl.regWrite  = 1'b1;
        decCtrl.aluSrc    = 1'b1;
        decCtrl.resultSrc = 2'b10;
        decCtrl.jump      = 1'b1;
        decCtrl.jalr      = 1'b1;
      end
      OP_LUI: begin
        decCtrl.regWrite = 1'b1;
        decCtrl.aluSrc   = 1'b1;
        decCtrl.aluOp    = 2'b11;
        immSrc           = 3'b100;
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        decIllegal = 1'b1;
`endif
      end
    endcase
  end

  // Hazards: a load in E feeding a D-stage source stalls; a taken
  // branch/jump in E squashes D and E. The two never coincide.
  always_comb begin
    lwStall = (ctrlE.resultSrc == 2'b01) &&
              ((rdE == bus.rs1_d) || (rdE == bus.rs2_d)) &&
              !(ZERO_REG_GUARD && (rdE == '0));
    pcSrc   = ctrlE.jump || (ctrlE.branch && bus.zero_e);
    flushE  = lwStall || pcSrc;
  end

  // D->E register; a flush loads a bubble, reset takes precedence.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      ctrlE <= '0;
      rdE   <= '0;
    end else begin
      ctrlE <= decCtrl;
      rdE   <= bus.rd_d;
    end
  end

  // E->M and M->W registers advance every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      resultSrcM <= 2'b00;
      rdM        <= '0;
      regWriteW  <= 1'b0;
      resultSrcW <= 2'b00;
      rdW        <= '0;
    end else begin
      regWriteM  <= ctrlE.regWrite;
      memWriteM  <= ctrlE.memWrite;
      resultSrcM <= ctrlE.resultSrc;
      rdM        <= rdE;
      regWriteW  <= regWriteM;
      resultSrcW <= resultSrcM;
      rdW        <= rdM;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Illegal flag travels with the bundle and is cleared by bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegalE <= 1'b0;
      illegalM <= 1'b0;
      illegalW <= 1'b0;
    end else begin
      illegalE <= decIllegal && !flushE;
      illegalM <= illegalE;
      illegalW <= illegalM;
    end
  end
  assign bus.illegal_w = illegalW;
`else
  assign bus.illegal_w = 1'b0;
`endif

  assign bus.imm_src_d    = immSrc;
  assign bus.reg_write_e  = ctrlE.regWrite;
  assign bus.mem_write_e  = ctrlE.memWrite;
  assign bus.alu_src_e    = ctrlE.aluSrc;
  assign bus.branch_e     = ctrlE.branch;
  assign bus.jump_e       = ctrlE.jump;
  assign bus.jalr_e       = ctrlE.jalr;
  assign bus.result_src_e = ctrlE.resultSrc;
  assign bus.alu_op_e     = ctrlE.aluOp;
  assign bus.rd_e         = rdE;
  assign bus.pc_src_e     = pcSrc;
  assign bus.reg_write_m  = regWriteM;
  assign bus.mem_write_m  = memWriteM;
  assign bus.result_src_m = resultSrcM;
  assign bus.rd_m         = rdM;
  assign bus.reg_write_w  = regWriteW;
  assign bus.result_src_w = resultSrcW;
  assign bus.rd_w         = rdW;
  assign bus.stall_f      = lwStall;
  assign bus.stall_d      = lwStall;
  assign bus.flush_d      = pcSrc;
  assign bus.flush_e      = flushE;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb_ctrl_pipe_unit: scoreboard bench for ctrl_pipe_unit. Two instances run
// side by side (ZERO_REG_GUARD=1 and =0) on identical stimulus. The reference
// model tracks which instruction occupies E, M and W and derives every output
// from the decode table.
module tb_ctrl_pipe_unit;

  localparam bit [6:0] LW   = 7'b0000011;
  localparam bit [6:0] SW   = 7'b0100011;
  localparam bit [6:0] RT   = 7'b0110011;
  localparam bit [6:0] IALU = 7'b0010011;
  localparam bit [6:0] BEQ  = 7'b1100011;
  localparam bit [6:0] JAL  = 7'b1101111;
  localparam bit [6:0] JALR = 7'b1100111;
  localparam bit [6:0] LUI  = 7'b0110111;
  localparam bit [6:0] BAD  = 7'b1111111;

  typedef struct packed {
    bit       rw, mw, as, br, j, jr;
    bit [1:0] rs, ao;
    bit [2:0] imm;
    bit       ill;
  } ctl_t;

  typedef struct packed {
    bit       valid;
    bit [6:0] op;
    bit [4:0] rd;
  } slot_t;

  typedef struct {
    int          cyc;
    logic [40:0] e0;
    logic [40:0] e1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_unit_if #(.REG_ADDR_W(5)) bus0 ();
  ctrl_pipe_unit_if #(.REG_ADDR_W(5)) bus1 ();

  ctrl_pipe_unit #(.REG_ADDR_W(5), .ZERO_REG_GUARD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  ctrl_pipe_unit #(.REG_ADDR_W(5), .ZERO_REG_GUARD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  slot_t sE[2], sM[2], sW[2];
  bit    guard[2] = '{1'b1, 1'b0};
  exp_t  expQ[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cycle = 0;
  bit    lastStall = 1'b0;

  // Decode table straight from the opcode list.
  function automatic ctl_t decodeRef(bit [6:0] op);
    ctl_t c = '0;
    case (op)
      LW:   begin c.rw = 1; c.as = 1; c.rs = 2'b01; end
      SW:   begin c.as = 1; c.mw = 1; c.imm = 3'd1; end
      RT:   begin c.rw = 1; c.ao = 2'b10; end
      IALU: begin c.rw = 1; c.as = 1; c.ao = 2'b10; end
      BEQ:  begin c.br = 1; c.ao = 2'b01; c.imm = 3'd2; end
      JAL:  begin c.rw = 1; c.rs = 2'b10; c.j = 1; c.imm = 3'd3; end
      JALR: begin c.rw = 1; c.as = 1; c.rs = 2'b10; c.j = 1; c.jr = 1; end
      LUI:  begin c.rw = 1; c.as = 1; c.ao = 2'b11; c.imm = 3'd4; end
      default: c.ill = 1;
    endcase
    return c;
  endfunction

  function automatic ctl_t slotCtl(slot_t s);
    return s.valid ? decodeRef(s.op) : ctl_t'(0);
  endfunction

  function automatic bit stallRef(int k, bit [4:0] s1, bit [4:0] s2);
    return sE[k].valid && sE[k].op == LW && (sE[k].rd == s1 || sE[k].rd == s2)
           && !(guard[k] && sE[k].rd == 5'd0);
  endfunction

  function automatic bit pcSrcRef(int k, bit z);
    ctl_t c = slotCtl(sE[k]);
    return c.j || (c.br && z);
  endfunction

  function automatic logic [40:0] expectOut(int k, bit [6:0] op, bit [4:0] s1,
                                            bit [4:0] s2, bit z);
    ctl_t ce = slotCtl(sE[k]);
    ctl_t cm = slotCtl(sM[k]);
    ctl_t cw = slotCtl(sW[k]);
    bit   st = stallRef(k, s1, s2);
    bit   pc = pcSrcRef(k, z);
    bit   ill;
    bit [4:0] rdE = sE[k].valid ? sE[k].rd : 5'd0;
    bit [4:0] rdM = sM[k].valid ? sM[k].rd : 5'd0;
    bit [4:0] rdW = sW[k].valid ? sW[k].rd : 5'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    ill = cw.ill;
`else
    ill = 1'b0;
`endif
    return {decodeRef(op).imm, ce.rw, ce.mw, ce.as, ce.br, ce.j, ce.jr, ce.rs,
            ce.ao, rdE, pc, cm.rw, cm.mw, cm.rs, rdM, cw.rw, cw.rs, rdW,
            st, st, pc, st | pc, ill};
  endfunction

  // One cycle: drive at negedge, queue the expected outputs, advance the model.
  task automatic step(input bit r, input bit [6:0] op, input bit [4:0] s1,
                      input bit [4:0] s2, input bit [4:0] d, input bit z,
                      input bit chk);
    exp_t x;
    @(negedge clk);
    cycle++;
    rst = r;
    bus0.op_d = op; bus0.rs1_d = s1; bus0.rs2_d = s2; bus0.rd_d = d; bus0.zero_e = z;
    bus1.op_d = op; bus1.rs1_d = s1; bus1.rs2_d = s2; bus1.rd_d = d; bus1.zero_e = z;
    if (chk) begin
      x.cyc = cycle;
      x.e0 = expectOut(0, op, s1, s2, z);
      x.e1 = expectOut(1, op, s1, s2, z);
      expQ.push_back(x);
    end
    lastStall = stallRef(0, s1, s2);
    for (int k = 0; k < 2; k++) begin
      bit fl = stallRef(k, s1, s2) || pcSrcRef(k, z);
      if (r) begin
        sE[k] = '0; sM[k] = '0; sW[k] = '0;
      end else begin
        sW[k] = sM[k];
        sM[k] = sE[k];
        sE[k] = fl ? slot_t'(0) : slot_t'({1'b1, op, d});
      end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, IALU, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle the outputs are sampled mid-cycle and compared.
  initial begin
    exp_t        x;
    logic [40:0] a0, a1;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        a0 = {bus0.imm_src_d, bus0.reg_write_e, bus0.mem_write_e, bus0.alu_src_e,
              bus0.branch_e, bus0.jump_e, bus0.jalr_e, bus0.result_src_e,
              bus0.alu_op_e, bus0.rd_e, bus0.pc_src_e, bus0.reg_write_m,
              bus0.mem_write_m, bus0.result_src_m, bus0.rd_m, bus0.reg_write_w,
              bus0.result_src_w, bus0.rd_w, bus0.stall_f, bus0.stall_d,
              bus0.flush_d, bus0.flush_e, bus0.illegal_w};
        a1 = {bus1.imm_src_d, bus1.reg_write_e, bus1.mem_write_e, bus1.alu_src_e,
              bus1.branch_e, bus1.jump_e, bus1.jalr_e, bus1.result_src_e,
              bus1.alu_op_e, bus1.rd_e, bus1.pc_src_e, bus1.reg_write_m,
              bus1.mem_write_m, bus1.result_src_m, bus1.rd_m, bus1.reg_write_w,
              bus1.result_src_w, bus1.rd_w, bus1.stall_f, bus1.stall_d,
              bus1.flush_d, bus1.flush_e, bus1.illegal_w};
        vectors += 2;
        if (a0 !== x.e0) begin
          miscompares++;
          $display("FAIL guard1 outputs cycle %0d: got %h expected %h", x.cyc, a0, x.e0);
        end
        if (a1 !== x.e1) begin
          miscompares++;
          $display("FAIL guard0 outputs cycle %0d: got %h expected %h", x.cyc, a1, x.e1);
        end
      end
    end
  end

  initial begin
    bit [6:0] ops[8] = '{LW, SW, RT, IALU, BEQ, JAL, JALR, LUI};
    bit [6:0] op;
    bit [4:0] s1, s2, d;
    bit       z, r;
    int       waitCnt;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin sE[k] = '0; sM[k] = '0; sW[k] = '0; end

    // Reset from unknown state, then check the cleared state.
    step(1'b1, IALU, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0);
    step(1'b1, IALU, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1);

    // R-type rd=5 walks to W; reset mid-stream clears it.
    step(1'b0, RT, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    nop(3);
    step(1'b0, LW, 5'd1, 5'd2, 5'd9, 1'b0, 1'b1);
    step(1'b1, RT, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1);
    nop(3);

    // Load-use: lw x7 then R reading x7 (held while stalled).
    step(1'b0, LW, 5'd1, 5'd2, 5'd7, 1'b0, 1'b1);
    step(1'b0, RT, 5'd3, 5'd7, 5'd8, 1'b0, 1'b1);
    step(1'b0, RT, 5'd3, 5'd7, 5'd8, 1'b0, 1'b1);
    nop(3);

    // lw x0 then consumer of x0: only the unguarded instance stalls.
    step(1'b0, LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    step(1'b0, RT, 5'd0, 5'd3, 5'd6, 1'b0, 1'b1);
    step(1'b0, RT, 5'd0, 5'd3, 5'd6, 1'b0, 1'b1);
    nop(3);

    // beq taken / not taken, jal regardless of zero_e.
    step(1'b0, BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    step(1'b0, IALU, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1);
    step(1'b0, BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    step(1'b0, IALU, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1);
    step(1'b0, JAL, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1);
    step(1'b0, IALU, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1);
    nop(3);

    // Opcode sweep.
    for (int i = 0; i < 8; i++) step(1'b0, ops[i], 5'd20, 5'd21, 5'(i + 10), 1'b0, 1'b1);
    nop(3);

    // Illegal opcode flows to W; then one squashed by a load-use flush.
    step(1'b0, BAD, 5'd31, 5'd31, 5'd12, 1'b0, 1'b1);
    nop(4);
    step(1'b0, LW, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    step(1'b0, BAD, 5'd3, 5'd31, 5'd12, 1'b0, 1'b1);
    step(1'b0, IALU, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1);
    nop(4);

    // Randomized traffic; D holds its instruction while stalled.
    op = IALU; s1 = 5'd31; s2 = 5'd31; d = 5'd31;
    for (int i = 0; i < 400; i++) begin
      if (!lastStall) begin
        int sel = $urandom_range(0, 9);
        op = (sel < 8) ? ops[sel] : 7'($urandom);
        s1 = 5'($urandom_range(0, 3));
        s2 = 5'($urandom_range(0, 3));
        d  = 5'($urandom_range(0, 3));
      end
      z = 1'($urandom);
      r = ($urandom_range(0, 49) == 0);
      step(r, op, s1, s2, d, z, 1'b1);
    end

    waitCnt = 0;
    while (expQ.size() > 0 && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    #3;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control unit for the RV32 five-stage core. It decodes the D-stage opcode into an extended control bundle covering lw, sw, R-type, I-ALU, beq, jal, jalr and lui. The bundle is carried through D→E→M→W pipeline registers. The block also computes load-use stall and branch/jump flush signals for the fetch/decode registers. It replaces the purely combinational decoder in the datapath's control path.

## Interface
Parameters:
- REG_ADDR_W, 5, width of register indices (4 for an RV32E build).
- ZERO_REG_GUARD, 1, when 1, register index 0 never causes a load-use hazard.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- op_d  in  7  opcode of instruction in D.
- rs1_d, rs2_d  in  REG_ADDR_W  source indices in D.
- rd_d  in  REG_ADDR_W  destination index in D.
- zero_e  in  1  ALU zero flag from E.
- imm_src_d  out  3  immediate select, combinational: I=000, S=001, B=010, J=011, U=100.
- reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e  out  1  E-stage controls.
- result_src_e  out  2  00 ALU, 01 memory, 10 PC+4.
- alu_op_e  out  2  00 add, 01 sub/compare, 10 funct-decode, 11 pass srcB.
- rd_e  out  REG_ADDR_W  E-stage destination.
- pc_src_e  out  1  combinational: jump_e | (branch_e & zero_e).
- reg_write_m, mem_write_m  out  1; result_src_m  out  2; rd_m  out  REG_ADDR_W.
- reg_write_w  out  1; result_src_w  out  2; rd_w  out  REG_ADDR_W.
- stall_f, stall_d, flush_d, flush_e  out  1  hazard controls, combinational.
- illegal_w  out  1  illegal-opcode flag at W (see Configuration).

## Operation
Decode table (RegWrite/ALUSrc/MemWrite/ResultSrc/Branch/Jump/Jalr/ALUOp/ImmSrc):
- lw 0000011: 1/1/0/01/0/0/0/00/I.
- sw 0100011: 0/1/1/00/0/0/0/00/S.
- R 0110011: 1/0/0/00/0/0/0/10/I.
- I-ALU 0010011: 1/1/0/00/0/0/0/10/I.
- beq 1100011: 0/0/0/00/1/0/0/01/B.
- jal 1101111: 1/0/0/10/0/1/0/00/J.
- jalr 1100111: 1/1/0/10/0/1/1/00/I.
- lui 0110111: 1/1/0/00/0/0/0/11/U.
- Any other opcode: all controls 0, imm_src_d=000.

Hazards:
- Load-use: lwstall = (result_src_e==01) & (rd_e==rs1_d | rd_e==rs2_d) & !(ZERO_REG_GUARD & rd_e==0).
- stall_f = stall_d = lwstall.
- flush_d = pc_src_e.
- flush_e = lwstall | pc_src_e.
- Stages:
  - D→E register: loads the decoded bundle and rd_d. Loads a bubble (all controls 0, rd 0) when flush_e.
  - E→M and M→W registers: advance every cycle and are never stalled.
- lwstall and pc_src_e cannot be true together (E holds either a load or a control-transfer). No priority is needed; flush_e is their OR.

## Timing
- Synchronous reset: every pipeline register is cleared, so all _e/_m/_w outputs are 0. Combinational outputs then follow from the zero state: pc_src_e=0, stall_f/stall_d=0, flush_d=0, flush_e=0.
- Latency, op_d to stage: 1 cycle to _e, 2 cycles to _m, 3 cycles to _w.
- imm_src_d has zero latency.
- A bubble inserted on flush_e appears at _m one cycle later and at _w two cycles later.
- Reset asserted mid-stream discards all in-flight controls on that edge. No partial state survives.
- rst dominates flush_e.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An opcode outside the decode table sets an illegal bit. The bit is pipelined alongside the bundle (cleared by bubbles and reset) and appears on illegal_w 3 cycles later.
  - Controls for that instruction are still all 0.
- Not defined: illegal_w is tied to 0 and no illegal bit is stored.

## Test plan
- Reset, then op_d=0110011, rd_d=5 for one cycle → reg_write_e=1, alu_op_e=10 in cycle 1; reg_write_w=1, rd_w=5 in cycle 3; rst high → all outputs 0 next edge.
- lw rd_d=7, then next D op=R with rs2_d=7 → stall_f=stall_d=flush_e=1 for exactly one cycle; the following E cycle holds all-zero controls; R decodes into E one cycle later.
- lw with rd_d=0 followed by a consumer with rs1_d=0, ZERO_REG_GUARD=1 → no stall; same with ZERO_REG_GUARD=0 → one-cycle stall.
- beq in E with zero_e=1 → pc_src_e=flush_d=flush_e=1; with zero_e=0 → all 0. jal in E → pc_src_e=1 regardless of zero_e.
- Sweep all 8 opcodes → bundle and imm_src_d match the decode table; jalr → result_src_e=10, jalr_e=1; lui → alu_op_e=11, imm_src_d=100.
- With CTRL_ILLEGAL_TRAP_EN: op_d=1111111 → illegal_w=1 exactly 3 cycles later with all controls 0; the same op followed by flush_e in D→E → illegal_w stays 0.
